reg_bank_p: RTL and testbench
=============================

// Module: reg_bank_p
// PURPOSE
//  Parametrised register bank for the datapath/CU designs (divider, multiplier, GCD).
//  - One write port fed by a 5-source input mux; three runtime-addressed read ports (ALU A, ALU B, feedback).
//  - Optional write-to-read bypass; per-register written bitmap.
//  - Two-register result capture with a valid/ready handshake towards the consumer.
// PARAMETERS
//  DW      8   data width of every register and data port
//  NREG    16  number of registers (>=2)
//  AW      $clog2(NREG)  address width (derived, not overridden)
//  BYPASS  1   1: read ports return write data when rd_addr==wr_addr and we=1; 0: read registered value
//  Q_IDX   3   register captured as quotient/result 0
//  R_IDX   7   register captured as remainder/result 1
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous active-high reset
//  in_sel     in   3   write-source select: 0 in_a, 1 in_b, 2 cu_const, 3 alu_out, 4..7 feedback read
//  in_a       in   DW  external operand A
//  in_b       in   DW  external operand B
//  cu_const   in   DW  constant from control unit
//  alu_out    in   DW  ALU result
//  we         in   1   write enable
//  wr_addr    in   AW  write address
//  rd_addr_a  in   AW  ALU operand A read address
//  rd_addr_b  in   AW  ALU operand B read address
//  rd_addr_fb in   AW  feedback read address (register-to-register move source)
//  alu_in_a   out  DW  reg[rd_addr_a] (bypassed per BYPASS)
//  alu_in_b   out  DW  reg[rd_addr_b] (bypassed per BYPASS)
//  written    out  NREG bit i set once reg i has been written since reset
//  res_commit in   1   CU pulse: capture reg[Q_IDX], reg[R_IDX]
//  res_valid  out  1   captured result held and valid
//  res_ready  in   1   consumer accepts result
//  out_q      out  DW  captured reg[Q_IDX]
//  out_r      out  DW  captured reg[R_IDX]
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge): all regs, written, out_q, out_r = 0; res_valid=0; FSM->IDLE. rst overrides we/res_commit.
//  - Write: on clk edge with we=1, reg[wr_addr] <= mux(in_sel); written[wr_addr] <= 1. we=0: no reg changes (decode fully specified, no latches).
//  - wr_addr >= NREG (non-power-of-2 NREG): write dropped, written unchanged.
//  - Reads: combinational, zero latency. Address >= NREG returns 0.
//  - Feedback source (in_sel 4..7) reads the pre-write value of reg[rd_addr_fb], never bypassed; rd_addr_fb==wr_addr is a legal in-place move.
//  - BYPASS=1 and we=1 and rd_addr_x==wr_addr: alu_in_x = write-mux value this cycle; BYPASS=0: old value until next edge.
//  - Result FSM, states IDLE, HOLD:
//    IDLE: res_commit=1 -> latch out_q/out_r from reg[Q_IDX]/reg[R_IDX] (post-write values if same-cycle write hits them), ->HOLD, res_valid=1.
//    HOLD: res_ready=1 -> IDLE, res_valid=0, out_q/out_r hold last value.
//    HOLD: res_commit=1 and res_ready=1 same cycle -> re-latch, stay HOLD (back-to-back).
//    HOLD: res_commit=1 and res_ready=0 -> commit ignored, held data stable (no overwrite while valid).
//  - out_q/out_r change only on a capture; valid/data stable while res_valid=1 and res_ready=0.
//  - rst in HOLD: res_valid drops next edge; pending result discarded.
// STRUCTURE
//  - Shared package: in_sel encodings (SRC_IN_A..SRC_FB), result FSM state enum, default DW/NREG.
//  - One sub-module: reg_bank_src_mux (in_sel -> write data); storage, decode and FSM inline.
// TESTING
//  - Reset: rst=1 one cycle, regs preloaded -> all reads 0, written=0, res_valid=0, out_q=out_r=0.
//  - Sources: we=1 wr_addr=1 in_sel=0 in_a=8'hA5; wr_addr=2 in_sel=3 alu_out=8'h3C -> alu_in_a(rd 1)=A5, alu_in_b(rd 2)=3C, written=16'h0006.
//  - Move/bypass: reg5=8'h11, in_sel=4 rd_addr_fb=5 wr_addr=6 -> reg6=11; BYPASS=1 rd_addr_a=6 same cycle -> alu_in_a=11; BYPASS=0 -> 00.
//  - we=0 with wr_addr=3 in_a=FF for 10 cycles -> reg3 unchanged, written[3]=0.
//  - Handshake: reg3=07 reg7=02, res_commit, res_ready=0 3 cycles -> res_valid=1, out_q=07 out_r=02 stable; second commit with reg3=09 ignored; res_ready=1 -> res_valid=0 next edge.
//  - Back-to-back: HOLD with res_commit=res_ready=1, reg3=0A -> stays HOLD, out_q=0A; rst mid-HOLD -> res_valid=0, out_q=0.

Source files
------------

// File: rtl/reg_bank_p_pkg.sv
// Shared definitions for the reg_bank_p register bank: write-source encodings,
// result FSM state constants and default geometry.
package reg_bank_p_pkg;

  localparam int DEF_DW   = 8;
  localparam int DEF_NREG = 16;

  // Codes 4..7 all select the feedback read port.
  typedef enum logic [2:0] {
    SRC_IN_A     = 3'd0,
    SRC_IN_B     = 3'd1,
    SRC_CU_CONST = 3'd2,
    SRC_ALU      = 3'd3,
    SRC_FB       = 3'd4
  } src_sel_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/reg_bank_p_if.sv
// Bus bundle between a control unit (master) and the register bank (slave):
// write port, read addresses/data and the result valid/ready handshake.
interface reg_bank_p_if
  import reg_bank_p_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG
);
  localparam int AW = $clog2(NREG);

  logic [2:0]      in_sel;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic [DW-1:0]   cu_const;
  logic [DW-1:0]   alu_out;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  logic [AW-1:0]   rd_addr_fb;
  logic [DW-1:0]   alu_in_a;
  logic [DW-1:0]   alu_in_b;
  logic [NREG-1:0] written;
  logic            res_commit;
  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   out_q;
  logic [DW-1:0]   out_r;

  modport master (
    output in_sel, in_a, in_b, cu_const, alu_out, we, wr_addr,
           rd_addr_a, rd_addr_b, rd_addr_fb, res_commit, res_ready,
    input  alu_in_a, alu_in_b, written, res_valid, out_q, out_r
  );

  modport slave (
    input  in_sel, in_a, in_b, cu_const, alu_out, we, wr_addr,
           rd_addr_a, rd_addr_b, rd_addr_fb, res_commit, res_ready,
    output alu_in_a, alu_in_b, written, res_valid, out_q, out_r
  );

endinterface

// File: rtl/reg_bank_src_mux.sv
// Write-data source selector for the register bank.
module reg_bank_src_mux
  import reg_bank_p_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [2:0]    in_sel,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] cu_const,
  input  logic [DW-1:0] alu_out,
  input  logic [DW-1:0] fb_data,
  output logic [DW-1:0] wr_data
);

  always_comb begin
    case (in_sel)
      SRC_IN_A:     wr_data = in_a;
      SRC_IN_B:     wr_data = in_b;
      SRC_CU_CONST: wr_data = cu_const;
      SRC_ALU:      wr_data = alu_out;
      default:      wr_data = fb_data;
    endcase
  end

endmodule

// File: rtl/reg_bank_p.sv
// Parametrised register bank: one muxed write port, three read ports with
// optional write bypass, written bitmap, and a two-register result capture.
module reg_bank_p
  import reg_bank_p_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NREG   = DEF_NREG,
  parameter int BYPASS = 1,
  parameter int Q_IDX  = 3,
  parameter int R_IDX  = 7
) (
  input logic         clk,
  input logic         rst,
  reg_bank_p_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] written_q, written_d;
  logic [0:0]      state_q, state_d;
  logic [DW-1:0]   out_q_q, out_q_d;
  logic [DW-1:0]   out_r_q, out_r_d;
  logic [DW-1:0]   fb_data;
  logic [DW-1:0]   wr_data;
  logic            wr_ok;
  logic            capture;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return int'(addr) < NREG;
  endfunction

  // Feedback always sees the pre-write value, so in-place moves are safe.
  assign fb_data = in_range(bus.rd_addr_fb) ? regs_q[bus.rd_addr_fb] : '0;

  reg_bank_src_mux #(.DW(DW)) u_src_mux (
    .in_sel   (bus.in_sel),
    .in_a     (bus.in_a),
    .in_b     (bus.in_b),
    .cu_const (bus.cu_const),
    .alu_out  (bus.alu_out),
    .fb_data  (fb_data),
    .wr_data  (wr_data)
  );

  assign wr_ok = bus.we && in_range(bus.wr_addr);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    regs_d    = regs_q;
    written_d = written_q;
    if (wr_ok) begin
      regs_d[bus.wr_addr]    = wr_data;
      written_d[bus.wr_addr] = 1'b1;
    end
  end

  always_comb begin
    bus.alu_in_a = in_range(bus.rd_addr_a) ? regs_q[bus.rd_addr_a] : '0;
    bus.alu_in_b = in_range(bus.rd_addr_b) ? regs_q[bus.rd_addr_b] : '0;
    if (BYPASS != 0 && wr_ok && bus.rd_addr_a == bus.wr_addr) bus.alu_in_a = wr_data;
    if (BYPASS != 0 && wr_ok && bus.rd_addr_b == bus.wr_addr) bus.alu_in_b = wr_data;
  end

  // A commit is accepted when idle, or when the held result leaves this same cycle.
  always_comb begin
    state_d = state_q;
    out_q_d = out_q_q;
    out_r_d = out_r_q;
    capture = bus.res_commit && (state_q == ST_IDLE || bus.res_ready);
    if (capture) begin
      state_d = ST_HOLD;
      out_q_d = regs_d[Q_IDX];
      out_r_d = regs_d[R_IDX];
    end else if (state_q == ST_HOLD && bus.res_ready) begin
      state_d = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset because reads after reset must return zero.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      written_q <= '0;
      state_q   <= ST_IDLE;
      out_q_q   <= '0;
      out_r_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      written_q <= written_d;
      state_q   <= state_d;
      out_q_q   <= out_q_d;
      out_r_q   <= out_r_d;
    end
  end

  assign bus.written   = written_q;
  assign bus.res_valid = (state_q == ST_HOLD);
  assign bus.out_q     = out_q_q;
  assign bus.out_r     = out_r_q;

endmodule

// File: tb/tb_reg_bank_p.sv
// Self-checking bench for reg_bank_p: BYPASS=1 and BYPASS=0 instances share stimulus
// and are compared against an array-based reference model.
module tb_reg_bank_p;
  import reg_bank_p_pkg::*;

  localparam int DW   = 8;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_p_if #(.DW(DW), .NREG(NREG)) b1 ();
  reg_bank_p_if #(.DW(DW), .NREG(NREG)) b0 ();

  reg_bank_p #(.DW(DW), .NREG(NREG), .BYPASS(1), .Q_IDX(3), .R_IDX(7)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));
  reg_bank_p #(.DW(DW), .NREG(NREG), .BYPASS(0), .Q_IDX(3), .R_IDX(7)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));

  assign b0.in_sel     = b1.in_sel;
  assign b0.in_a       = b1.in_a;
  assign b0.in_b       = b1.in_b;
  assign b0.cu_const   = b1.cu_const;
  assign b0.alu_out    = b1.alu_out;
  assign b0.we         = b1.we;
  assign b0.wr_addr    = b1.wr_addr;
  assign b0.rd_addr_a  = b1.rd_addr_a;
  assign b0.rd_addr_b  = b1.rd_addr_b;
  assign b0.rd_addr_fb = b1.rd_addr_fb;
  assign b0.res_commit = b1.res_commit;
  assign b0.res_ready  = b1.res_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  m_reg [NREG];
  logic [15:0] m_wr;
  logic        m_valid;
  logic [7:0]  m_q, m_r;

  typedef struct {
    logic [2:0]  sel;
    logic [3:0]  wr;
    logic [7:0]  data;
    logic [3:0]  fb;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [15:0] exp_wr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_src();
    case (b1.in_sel)
      3'd0:    return b1.in_a;
      3'd1:    return b1.in_b;
      3'd2:    return b1.cu_const;
      3'd3:    return b1.alu_out;
      default: return m_reg[b1.rd_addr_fb];
    endcase
  endfunction

  function automatic logic [7:0] exp_read(input logic [3:0] addr, input bit byp,
                                          input logic [7:0] src);
    if (byp && b1.we && addr == b1.wr_addr) return src;
    return m_reg[addr];
  endfunction

  task automatic model_update(input logic [7:0] src);
    logic [7:0] nr [NREG];
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_wr = '0; m_valid = 1'b0; m_q = '0; m_r = '0;
    end else begin
      nr = m_reg;
      if (b1.we) begin
        nr[b1.wr_addr]   = src;
        m_wr[b1.wr_addr] = 1'b1;
      end
      if (b1.res_commit && (!m_valid || b1.res_ready)) begin
        m_q = nr[3]; m_r = nr[7]; m_valid = 1'b1;
      end else if (b1.res_ready) begin
        m_valid = 1'b0;
      end
      m_reg = nr;
    end
  endtask

  // Called just after a negedge with inputs set; checks outputs, crosses one posedge.
  task automatic clk_step();
    logic [7:0] src;
    #1;
    src = model_src();
    check("alu_a_byp",  b1.alu_in_a, exp_read(b1.rd_addr_a, 1'b1, src));
    check("alu_b_byp",  b1.alu_in_b, exp_read(b1.rd_addr_b, 1'b1, src));
    check("alu_a_nbyp", b0.alu_in_a, exp_read(b1.rd_addr_a, 1'b0, src));
    check("alu_b_nbyp", b0.alu_in_b, exp_read(b1.rd_addr_b, 1'b0, src));
    check("written",    b1.written,  m_wr);
    check("written_nb", b0.written,  m_wr);
    check("res_valid",  b1.res_valid, m_valid);
    check("res_valid_nb", b0.res_valid, m_valid);
    check("out_q",      b1.out_q, m_q);
    check("out_r",      b1.out_r, m_r);
    check("out_q_nb",   b0.out_q, m_q);
    @(posedge clk);
    model_update(src);
    @(negedge clk);
  endtask

  task automatic set_src(input logic [2:0] sel, input logic [7:0] data);
    b1.in_sel   = sel;
    b1.in_a     = (sel == 3'd0) ? data : 8'hE1;
    b1.in_b     = (sel == 3'd1) ? data : 8'hE2;
    b1.cu_const = (sel == 3'd2) ? data : 8'hE3;
    b1.alu_out  = (sel == 3'd3) ? data : 8'hE4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (m_reg[i]) m_reg[i] = '0;
    m_wr = '0; m_valid = 1'b0; m_q = '0; m_r = '0;
    b1.we = 1'b0; b1.wr_addr = '0; b1.rd_addr_a = '0; b1.rd_addr_b = '0;
    b1.rd_addr_fb = '0; b1.res_commit = 1'b0; b1.res_ready = 1'b0;
    set_src(3'd0, 8'h00);

    vecs[0] = '{3'd0, 4'd1,  8'hA5, 4'd0,  4'd1,  4'd2,  8'hA5, 8'h00, 16'h0002};
    vecs[1] = '{3'd3, 4'd2,  8'h3C, 4'd0,  4'd1,  4'd2,  8'hA5, 8'h3C, 16'h0006};
    vecs[2] = '{3'd1, 4'd5,  8'h11, 4'd0,  4'd5,  4'd2,  8'h11, 8'h3C, 16'h0026};
    vecs[3] = '{3'd4, 4'd6,  8'h00, 4'd5,  4'd6,  4'd5,  8'h11, 8'h11, 16'h0066};
    vecs[4] = '{3'd2, 4'd15, 8'h5A, 4'd0,  4'd15, 4'd0,  8'h5A, 8'h00, 16'h8066};
    vecs[5] = '{3'd7, 4'd1,  8'h00, 4'd1,  4'd1,  4'd6,  8'hA5, 8'h11, 16'h8066};
    vecs[6] = '{3'd5, 4'd0,  8'h00, 4'd15, 4'd0,  4'd15, 8'h5A, 8'h5A, 16'h8067};

    // Initial reset
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clk_step();
    rst = 1'b0;

    // Table-driven write/read vectors
    foreach (vecs[i]) begin
      b1.we = 1'b1; b1.wr_addr = vecs[i].wr; b1.rd_addr_fb = vecs[i].fb;
      set_src(vecs[i].sel, vecs[i].data);
      clk_step();
      b1.we = 1'b0; b1.rd_addr_a = vecs[i].rd_a; b1.rd_addr_b = vecs[i].rd_b;
      #1;
      check($sformatf("vec%0d_a", i),    b1.alu_in_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i),    b1.alu_in_b, vecs[i].exp_b);
      check($sformatf("vec%0d_a_nb", i), b0.alu_in_a, vecs[i].exp_a);
      check($sformatf("vec%0d_wr", i),   b1.written,  vecs[i].exp_wr);
      clk_step();
    end

    // Reset with preloaded registers
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      b1.rd_addr_a = 4'(i); b1.rd_addr_b = 4'(i);
      #1;
      check($sformatf("rst_rd%0d", i), b1.alu_in_a, 8'h00);
      check($sformatf("rst_rd%0d_nb", i), b0.alu_in_b, 8'h00);
    end
    check("rst_written", b1.written, 16'h0000);
    check("rst_valid", b1.res_valid, 1'b0);
    check("rst_out_q", b1.out_q, 8'h00);
    check("rst_out_r", b1.out_r, 8'h00);

    // Register move with bypass vs. no bypass
    b1.we = 1'b1; b1.wr_addr = 4'd5; set_src(3'd1, 8'h11);
    clk_step();
    b1.wr_addr = 4'd6; b1.rd_addr_fb = 4'd5; b1.rd_addr_a = 4'd6; set_src(3'd4, 8'h00);
    #1;
    check("move_byp_same_cycle",  b1.alu_in_a, 8'h11);
    check("move_nbyp_same_cycle", b0.alu_in_a, 8'h00);
    clk_step();
    b1.we = 1'b0;
    #1;
    check("move_byp_after",  b1.alu_in_a, 8'h11);
    check("move_nbyp_after", b0.alu_in_a, 8'h11);

    // we=0 must never write
    b1.we = 1'b0; b1.wr_addr = 4'd3; set_src(3'd0, 8'hFF);
    repeat (10) clk_step();
    b1.rd_addr_a = 4'd3;
    #1;
    check("we0_reg3", b1.alu_in_a, 8'h00);
    check("we0_written3", b1.written[3], 1'b0);

    // Handshake: hold while not ready, ignore second commit
    b1.we = 1'b1; b1.wr_addr = 4'd3; set_src(3'd0, 8'h07); clk_step();
    b1.wr_addr = 4'd7; set_src(3'd0, 8'h02); clk_step();
    b1.we = 1'b0; b1.res_commit = 1'b1; b1.res_ready = 1'b0; clk_step();
    b1.res_commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold%0d_valid", i), b1.res_valid, 1'b1);
      check($sformatf("hold%0d_q", i), b1.out_q, 8'h07);
      check($sformatf("hold%0d_r", i), b1.out_r, 8'h02);
      clk_step();
    end
    b1.we = 1'b1; b1.wr_addr = 4'd3; set_src(3'd0, 8'h09); b1.res_commit = 1'b1;
    clk_step();
    b1.we = 1'b0; b1.res_commit = 1'b0;
    #1;
    check("ignored_commit_q", b1.out_q, 8'h07);
    check("ignored_commit_valid", b1.res_valid, 1'b1);
    b1.res_ready = 1'b1; clk_step();
    b1.res_ready = 1'b0;
    #1;
    check("accept_valid", b1.res_valid, 1'b0);
    check("accept_q_kept", b1.out_q, 8'h07);

    // Back-to-back commit with same-cycle write, then reset while holding
    b1.res_commit = 1'b1; clk_step();
    b1.res_commit = 1'b0;
    #1;
    check("b2b_first_q", b1.out_q, 8'h09);
    b1.we = 1'b1; b1.wr_addr = 4'd3; set_src(3'd0, 8'h0A);
    b1.res_commit = 1'b1; b1.res_ready = 1'b1;
    clk_step();
    b1.we = 1'b0; b1.res_commit = 1'b0; b1.res_ready = 1'b0;
    #1;
    check("b2b_valid", b1.res_valid, 1'b1);
    check("b2b_q", b1.out_q, 8'h0A);
    check("b2b_r", b1.out_r, 8'h02);
    rst = 1'b1; clk_step();
    rst = 1'b0;
    #1;
    check("rst_hold_valid", b1.res_valid, 1'b0);
    check("rst_hold_q", b1.out_q, 8'h00);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 39) == 0);
      b1.we         = ($urandom_range(0, 3) != 0);
      b1.in_sel     = 3'($urandom);
      b1.in_a       = 8'($urandom);
      b1.in_b       = 8'($urandom);
      b1.cu_const   = 8'($urandom);
      b1.alu_out    = 8'($urandom);
      b1.wr_addr    = 4'($urandom);
      b1.rd_addr_a  = 4'($urandom);
      b1.rd_addr_b  = 4'($urandom);
      b1.rd_addr_fb = 4'($urandom);
      b1.res_commit = ($urandom_range(0, 3) == 0);
      b1.res_ready  = 1'($urandom);
      clk_step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
